// File: rtl/key_loader_pkg.sv
// Shared definitions for the serial key loader: FSM state encoding and parameter defaults.
package key_loader_pkg;
  localparam int unsigned KEY_W_DEF     = 3;
  localparam int unsigned MAX_TRIES_DEF = 3;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PAR,
    ARMED,
    LOCKOUT
  } state_t;
endpackage

// File: rtl/key_shift_reg.sv
// Shadow register for the incoming key: bit-indexed capture, bit counter and running XOR.
module key_shift_reg import key_loader_pkg::*; #(
  parameter int unsigned KEY_W = KEY_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             bit_in,
  output logic [KEY_W-1:0] shadow,
  output logic             parity,
  output logic             done
);
  localparam int unsigned CW = (KEY_W > 1) ? $clog2(KEY_W) : 1;

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
      count  <= '0;
      parity <= 1'b0;
    end else if (clear) begin
      shadow <= '0;
      count  <= '0;
      parity <= 1'b0;
    end else if (shift_en) begin
      shadow[count] <= bit_in;
      count         <= count + 1'b1;
      parity        <= parity ^ bit_in;
    end
  end

  // High while the final key bit is the one awaited.
  assign done = (count == CW'(KEY_W - 1));
endmodule

// File: rtl/key_loader.sv
// Serial key loader: collects KEY_W bits plus parity, arms the key on a good check, locks out after MAX_TRIES failures.
module key_loader import key_loader_pkg::*; #(
  parameter int unsigned KEY_W     = KEY_W_DEF,
  parameter int unsigned MAX_TRIES = MAX_TRIES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             s_valid,
  input  logic             s_data,
  output logic             s_ready,
  output logic [KEY_W-1:0] key_out,
  output logic             key_ok,
  output logic             busy,
  output logic             lockout
);
  localparam int unsigned FW = (MAX_TRIES > 0) ? $clog2(MAX_TRIES + 1) : 1;
  localparam logic [FW-1:0] LIMIT = FW'(MAX_TRIES);

  state_t           state;
  logic [FW-1:0]    fail_cnt;
  logic [FW-1:0]    fail_next;
  logic [KEY_W-1:0] shadow;
  logic             parity;
  logic             done;
  logic             shift_en;
  logic             clear;
  logic             xfer;

  assign xfer     = s_valid && s_ready;
  assign shift_en = xfer && (state == LOAD);
  assign clear    = ((state == IDLE) && start) || (xfer && (state == PAR));

  key_shift_reg #(.KEY_W(KEY_W)) u_shift (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear),
    .shift_en(shift_en),
    .bit_in  (s_data),
    .shadow  (shadow),
    .parity  (parity),
    .done    (done)
  );

  always_comb begin
    fail_next = fail_cnt;
    if (fail_cnt != LIMIT) fail_next = fail_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      fail_cnt <= '0;
      key_out  <= '0;
      key_ok   <= 1'b0;
      busy     <= 1'b0;
      s_ready  <= 1'b0;
      lockout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= LOAD;
            s_ready <= 1'b1;
            busy    <= 1'b1;
          end
        end
        LOAD: begin
          if (xfer && done) state <= PAR;
        end
        PAR: begin
          if (xfer) begin
            s_ready <= 1'b0;
            busy    <= 1'b0;
            // shadow is cleared on this same edge, so it is sampled into key_out here only on a pass
            if ((parity ^ s_data) == 1'b0) begin
              key_out <= shadow;
              key_ok  <= 1'b1;
              state   <= ARMED;
            end else begin
              fail_cnt <= fail_next;
              if (fail_next == LIMIT) begin
                state   <= LOCKOUT;
                lockout <= 1'b1;
              end else begin
                state <= IDLE;
              end
            end
          end
        end
        ARMED: begin
          state <= ARMED;
        end
        LOCKOUT: begin
          state <= LOCKOUT;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: doc/key_loader.md
KEY_LOADER -- requirements
Module: key_loader

Interface
REQ-001 Parameter KEY_W, default 3, number of key bits driven into the locked netlist.
REQ-002 Parameter MAX_TRIES, default 3, number of parity failures allowed before permanent lockout.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 start  input  1  single-cycle request to begin a key load.
REQ-006 s_valid  input  1  serial key bit present on s_data.
REQ-007 s_data  input  1  serial key bit; first transfer is key bit 0, then bit 1, and so on.
REQ-008 s_ready  output  1  block accepts a serial bit this cycle.
REQ-009 key_out  output  KEY_W  key bus to the locked netlist; bit i drives key_i.
REQ-010 key_ok  output  1  key_out holds a verified key.
REQ-011 busy  output  1  a load is in progress.
REQ-012 lockout  output  1  failure limit reached; the block is dead until reset.

Function
REQ-013 A transfer SHALL occur only on a cycle with s_valid=1 and s_ready=1; s_valid gaps SHALL stall without loss.
REQ-014 The FSM SHALL have states IDLE, LOAD, PAR, ARMED and LOCKOUT.
REQ-015 IDLE: s_ready=0, and start=1 SHALL enter LOAD with the bit counter cleared to 0.
REQ-016 LOAD: s_ready=1, and each transfer SHALL write s_data into shadow[count] and increment count.
REQ-017 The transfer with count=KEY_W-1 SHALL enter PAR.
REQ-018 PAR: s_ready=1, and the single transfer in this state is the parity bit p.
REQ-019 Parity check: if XOR(shadow)^p == 0, the same clock edge SHALL load key_out<=shadow, set key_ok=1 and enter ARMED.
REQ-020 On parity mismatch, the same edge SHALL clear shadow and increment fail_cnt.
REQ-021 After a mismatch, the FSM SHALL enter LOCKOUT if fail_cnt reaches MAX_TRIES; otherwise it SHALL return to IDLE.
REQ-022 ARMED is terminal until reset: s_ready=0, start ignored, key_out and key_ok held.
REQ-023 LOCKOUT is terminal until reset: lockout=1, s_ready=0, start ignored, key_out=0, key_ok=0.
REQ-024 start SHALL be ignored in LOAD and PAR, with no restart and no counter change.
REQ-025 s_valid SHALL be ignored in IDLE, ARMED and LOCKOUT.
REQ-026 Shadow contents SHALL never appear on key_out before a passing parity check.
REQ-027 key_out SHALL be 0 in every state except ARMED.
REQ-028 busy SHALL be 1 exactly in LOAD and PAR.
REQ-029 fail_cnt SHALL be wide enough to hold MAX_TRIES and SHALL saturate; it is never cleared except by reset.
REQ-030 Minimum latency SHALL be 1 start cycle plus KEY_W+1 transfer cycles; key_ok is visible on the cycle after the parity transfer.

Reset
REQ-031 rst_n=0 SHALL immediately force state=IDLE, shadow=0, count=0, fail_cnt=0, key_out=0, key_ok=0, busy=0, s_ready=0 and lockout=0.
REQ-032 Reset asserted in LOAD, PAR, ARMED or LOCKOUT SHALL discard all partial and verified key data.
REQ-033 Reset deassertion SHALL be synchronised by the integrator; the first active edge after deassertion sees IDLE.

Structure
REQ-034 A shared package SHALL hold the FSM state enum and the default values of KEY_W and MAX_TRIES.
REQ-035 One sub-module, key_shift_reg, SHALL hold the shadow register, bit counter and running XOR, with clear, shift-enable and a done flag.
REQ-036 FSM, fail counter and output register SHALL live in key_loader.
REQ-037 No combinational path SHALL exist from s_data to key_out.

Verification
REQ-038 Good load: start, then bits 1,0,1 and parity 0 -> key_out=3'b101, key_ok=1, busy=0 one cycle after the parity transfer.
REQ-039 Stalled load: same data with s_valid low for 2 cycles between every bit -> identical result; s_ready stays 1 throughout LOAD and PAR.
REQ-040 Bad parity: bits 1,1,0 with parity 1 -> key_out=0, key_ok=0, IDLE, fail_cnt=1; a subsequent good load of 0,1,1 with parity 0 -> key_out=3'b110.
REQ-041 Lockout: three consecutive bad-parity loads -> lockout=1 after the third; a fourth start with valid data -> no change, s_ready=0.
REQ-042 Armed freeze: after key_out=3'b101, start plus bits 0,0,0 and parity 0 -> key_out stays 3'b101, s_ready=0.
REQ-043 Mid-load reset: rst_n low after 2 bits -> all outputs 0 asynchronously; a fresh load after release succeeds with fail_cnt=0.
